// File: rtl/xpb_reduce_seq.sv
// Walks the chunks of one upper value through a shared xpb lookup ROM, one lookup per cycle,
// and sums the returned constants into a wide accumulator offered on a valid/ready port.
module xpb_reduce_seq #(
    parameter  int NUM_CHUNKS = 4,
    parameter  int CHUNK_W    = 5,
    parameter  int XPB_W      = 1024,
    localparam int ACC_W      = XPB_W + $clog2(NUM_CHUNKS + 1),
    localparam int SEL_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CHUNKS*CHUNK_W-1:0] in_upper,
    input  logic                          flush,
    output logic [SEL_W-1:0]              rom_sel,
    output logic [CHUNK_W-1:0]            rom_idx,
    input  logic [XPB_W-1:0]              rom_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data
);

    localparam int UP_W = NUM_CHUNKS * CHUNK_W;
    localparam logic [SEL_W-1:0] LAST_CHUNK = SEL_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   count_reg, count_next;
    logic               pending_reg, pending_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [UP_W-1:0]    upper_reg, upper_next;
    logic               in_ready_reg;
    logic [CHUNK_W-1:0] chunk [NUM_CHUNKS];

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
            assign chunk[gi] = upper_reg[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            pending_reg  <= 1'b0;
            acc_reg      <= '0;
            upper_reg    <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            pending_reg  <= pending_next;
            acc_reg      <= acc_next;
            upper_reg    <= upper_next;
            // Registered so in_ready stays low for the whole reset and rises on the first clock after.
            in_ready_reg <= (state_next == IDLE);
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        pending_next = 1'b0;
        acc_next     = acc_reg;
        upper_next   = upper_reg;

        // The ROM answers one cycle after an issue, so the add trails the issue by one cycle.
        if (pending_reg) begin
            acc_next = acc_reg + {{(ACC_W - XPB_W){1'b0}}, rom_data};
        end

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    upper_next = in_upper;
                    acc_next   = '0;
                    count_next = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                pending_next = 1'b1;
                if (count_reg == LAST_CHUNK) begin
                    count_next = '0;
                    state_next = DRAIN;
                end else begin
                    count_next = count_reg + SEL_W'(1);
                end
            end
            DRAIN: state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over everything, including an accept in IDLE and a word still in flight.
        if (flush) begin
            state_next   = IDLE;
            count_next   = '0;
            pending_next = 1'b0;
            acc_next     = '0;
        end
    end

    assign in_ready  = in_ready_reg;
    assign rom_sel   = (state_reg == ISSUE) ? count_reg : '0;
    assign rom_idx   = (state_reg == ISSUE) ? chunk[count_reg] : '0;
    assign out_valid = (state_reg == DONE);
    assign out_data  = acc_reg;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Randomized bench for xpb_reduce_seq: behavioural registered ROM plus a sum-of-lookups reference.
module tb_xpb_reduce_seq;

    localparam int NUM_CHUNKS = 4;
    localparam int CHUNK_W    = 5;
    localparam int XPB_W      = 1024;
    localparam int ACC_W      = XPB_W + $clog2(NUM_CHUNKS + 1);
    localparam int SEL_W      = 2;
    localparam int UP_W       = NUM_CHUNKS * CHUNK_W;
    localparam int DEPTH      = 1 << CHUNK_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [UP_W-1:0]   in_upper = '0;
    logic              flush = 1'b0;
    logic [SEL_W-1:0]  rom_sel;
    logic [CHUNK_W-1:0] rom_idx;
    logic [XPB_W-1:0]  rom_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_data;

    logic [XPB_W-1:0]  xpb [NUM_CHUNKS][DEPTH];

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int txn_count = 0;

    xpb_reduce_seq #(.NUM_CHUNKS(NUM_CHUNKS), .CHUNK_W(CHUNK_W), .XPB_W(XPB_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_upper(in_upper), .flush(flush), .rom_sel(rom_sel), .rom_idx(rom_idx),
        .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) rom_data <= xpb[rom_sel][rom_idx];

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h..%h want %h..%h", tag, obs[ACC_W-1 -: 35], obs[63:0],
                     exp[ACC_W-1 -: 35], exp[63:0]);
        end
    endtask

    function automatic logic [ACC_W-1:0] ref_sum(input logic [UP_W-1:0] u);
        logic [ACC_W-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            s = s + ACC_W'(xpb[k][u[k*CHUNK_W +: CHUNK_W]]);
        end
        return s;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_timeout", ACC_W'(in_ready), ACC_W'(1));
    endtask

    // One complete transaction; on return we sit at the negedge of the first IDLE cycle.
    task automatic run_txn(input logic [UP_W-1:0] u, input int bp, input int gap, output int acc_cyc);
        logic [ACC_W-1:0] exp;
        int lat;
        exp = ref_sum(u);
        repeat (gap) @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_upper = u;
        acc_cyc  = cycle;
        out_ready = (bp == 0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            check($sformatf("rom_sel[%0d]", k), ACC_W'(rom_sel), ACC_W'(k));
            check($sformatf("rom_idx[%0d]", k), ACC_W'(rom_idx), ACC_W'(u[k*CHUNK_W +: CHUNK_W]));
            if (k < NUM_CHUNKS - 1) @(negedge clk);
        end
        lat = NUM_CHUNKS;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("latency", ACC_W'(lat), ACC_W'(NUM_CHUNKS + 2));
        check("out_data", out_data, exp);
        check("ready_in_done", ACC_W'(in_ready), ACC_W'(0));
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check("bp_valid", ACC_W'(out_valid), ACC_W'(1));
            check("bp_data", out_data, exp);
            check("bp_ready", ACC_W'(in_ready), ACC_W'(0));
            check("bp_idx", ACC_W'(rom_idx), ACC_W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", ACC_W'(out_valid), ACC_W'(0));
        check("release_ready", ACC_W'(in_ready), ACC_W'(1));
        txn_count++;
        $display("txn %0d upper=%h lat=%0d bp=%0d sum_lo=%h", txn_count, u, lat, bp, exp[63:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3;
        logic [UP_W-1:0] u;
        logic seen_valid;

        for (int k = 0; k < NUM_CHUNKS; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int w = 0; w < XPB_W / 32; w++) xpb[k][i][w*32 +: 32] = $urandom;
            end
            xpb[k][0]  = '0;
            xpb[k][31] = '1;
        end
        xpb[0][1][XPB_W-1 -: 32] = 32'h16fffc8d;
        xpb[0][1][23:0]          = 24'hb580a3;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", ACC_W'(in_ready), ACC_W'(0));
        check("rst_valid", ACC_W'(out_valid), ACC_W'(0));
        check("rst_data", out_data, '0);
        check("rst_sel", ACC_W'(rom_sel), ACC_W'(0));
        check("rst_idx", ACC_W'(rom_idx), ACC_W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ACC_W'(in_ready), ACC_W'(1));

        // Zero, single chunk, full
        run_txn('0, 0, 0, c0);
        run_txn(20'h00001, 0, 0, c0);
        run_txn(20'hFFFFF, 0, 0, c0);

        // Long backpressure in DONE
        run_txn(UP_W'($urandom), 10, 1, c0);

        // Flush after two issues
        wait_ready();
        in_valid = 1'b1;
        in_upper = 20'h7BDEF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", ACC_W'(in_ready), ACC_W'(1));
        check("flush_valid", ACC_W'(out_valid), ACC_W'(0));
        check("flush_idx", ACC_W'(rom_idx), ACC_W'(0));
        check("flush_acc", out_data, '0);
        seen_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("flush_no_valid", ACC_W'(seen_valid), ACC_W'(0));
        run_txn(20'h00021, 0, 0, c0);

        // Flush in IDLE with in_valid high: nothing accepted
        in_valid = 1'b1;
        in_upper = 20'hFFFFF;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_ready", ACC_W'(in_ready), ACC_W'(1));
        check("idle_flush_idx", ACC_W'(rom_idx), ACC_W'(0));

        // Async reset in DRAIN
        wait_ready();
        in_valid = 1'b1;
        in_upper = 20'hFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", ACC_W'(out_valid), ACC_W'(0));
        check("arst_data", out_data, '0);
        check("arst_sel", ACC_W'(rom_sel), ACC_W'(0));
        check("arst_idx", ACC_W'(rom_idx), ACC_W'(0));
        check("arst_ready", ACC_W'(in_ready), ACC_W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back throughput
        run_txn(UP_W'($urandom), 0, 0, c0);
        run_txn(UP_W'($urandom), 0, 0, c1);
        run_txn(UP_W'($urandom), 0, 0, c2);
        run_txn(UP_W'($urandom), 0, 0, c3);
        check("period_a", ACC_W'(c1 - c0), ACC_W'(NUM_CHUNKS + 3));
        check("period_b", ACC_W'(c2 - c1), ACC_W'(NUM_CHUNKS + 3));
        check("period_c", ACC_W'(c3 - c2), ACC_W'(NUM_CHUNKS + 3));

        // Random mix
        for (int n = 0; n < 12; n++) begin
            u = UP_W'($urandom);
            run_txn(u, $urandom_range(0, 3), $urandom_range(0, 2), c0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
